// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding and
// default operand width.
package serial_add_ctrl_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// Single-bit full adder made of two half adders with the carries ORed together.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);

  logic s1, c1, c2;

  half_adder u_ha0 (.a_i(a_i), .b_i(b_i), .s_o(s1),  .c_o(c1));
  half_adder u_ha1 (.a_i(s1),  .b_i(c_i), .s_o(s_o), .c_o(c2));

  assign co_o = c1 | c2;

endmodule

// File: rtl/serial_add_ctrl_half_adder.sv
// Single-bit half adder; building block for the serial full adder.
module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);

  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands one bit per cycle,
// LSB first, and presents a registered sum/carry with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | one full-adder step per cycle, WIDTH cycles total
// DONE  | result loaded, done pulse; accepts a new start
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int              CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q, sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cf_q, carry_q, busy_q, done_q;

  logic             fa_s, fa_co;
  logic [WIDTH-1:0] res_d;

  full_adder u_fa (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .c_i (cf_q),
    .s_o (fa_s),
    .co_o(fa_co)
  );

  // New sum bit enters at the MSB so the first (LSB) bit lands at bit 0 after WIDTH steps.
  assign res_d = (res_q >> 1) | {fa_s, {(WIDTH-1){1'b0}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      cf_q    <= 1'b0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_SHIFT: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_d;
          cf_q  <= fa_co;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= res_d;
            carry_q <= fa_co;
          end
        end
        default: begin
          if (start) begin
            state_q <= ST_SHIFT;
            busy_q  <= 1'b1;
            a_q     <= a;
            b_q     <= b;
            cf_q    <= 1'b0;
            cnt_q   <= '0;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign carry = carry_q;

endmodule
